// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//
// 8N1 UART receiver feeding the SDRAM write-side FIFO. The asynchronous
// rs232_rx line is synchronised, each byte is recovered LSB first by sampling
// at mid-bit, and a good byte is pushed into the FIFO with a one-cycle write
// strobe. Bad stop bits and bytes dropped on a full FIFO are flagged with
// one-cycle pulses.
//
// Parameters:
//   BAUD_END      last value of the per-bit baud counter (bit = BAUD_END+1 clks)
//
// Ports:
//   sclk          system clock
//   s_rst_n       asynchronous active-low reset
//   rs232_rx      serial line, idles high
//   wfifo_full    write-side FIFO full (looked at only at the stop-bit sample)
//   wfifo_wr_en   one-cycle write strobe
//   wfifo_wr_data received byte, held between strobes
//   frame_err     one-cycle pulse: stop bit sampled low
//   overflow      one-cycle pulse: good byte dropped, FIFO full
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int unsigned BAUD_END = 5207
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic       rs232_rx,
  input  logic       wfifo_full,
  output logic       wfifo_wr_en,
  output logic [7:0] wfifo_wr_data,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned BAUD_M = BAUD_END / 2 - 1;

  localparam logic [12:0] BAUD_END_C = 13'(BAUD_END);
  localparam logic [12:0] BAUD_M_C   = 13'(BAUD_M);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Synchroniser chain, reset to the idle (high) level.
  logic       rx_r1_q;
  logic       rx_r2_q;
  logic       rx_r3_q;

  // Marks when rx_r3 holds a real line sample after reset; until then the
  // reset-forced highs would make a line held low look like a falling edge.
  logic [2:0] warm_q;
  logic       warm;

  state_t      state_q,     state_d;
  logic [12:0] baud_cnt_q,  baud_cnt_d;
  logic [2:0]  bit_cnt_q,   bit_cnt_d;
  logic [7:0]  shift_q,     shift_d;
  logic        wr_en_q,     wr_en_d;
  logic [7:0]  wr_data_q,   wr_data_d;
  logic        frame_err_q, frame_err_d;
  logic        overflow_q,  overflow_d;

  logic        start_edge;
  logic        strobe;
  logic        baud_wrap;
  logic [12:0] baud_next;

  assign warm       = warm_q[2];
  assign start_edge = rx_r3_q & ~rx_r2_q;
  assign strobe     = (baud_cnt_q == BAUD_M_C);
  assign baud_wrap  = (baud_cnt_q == BAUD_END_C);
  assign baud_next  = baud_wrap ? '0 : baud_cnt_q + 13'd1;

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (start_edge && warm) begin
          state_d = START;
        end
      end

      // The start bit is verified at mid-bit, but DATA is only entered at the
      // end of the start bit so that every later strobe falls mid data bit.
      START: begin
        baud_cnt_d = baud_next;
        if (strobe && rx_r2_q) begin
          state_d    = IDLE;
          baud_cnt_d = '0;
        end else if (baud_wrap) begin
          state_d    = DATA;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end

      DATA: begin
        baud_cnt_d = baud_next;
        if (strobe) begin
          shift_d = {rx_r2_q, shift_q[7:1]};
        end
        if (baud_wrap) begin
          if (bit_cnt_q == 3'd7) begin
            state_d    = STOP;
            baud_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      // Leave at mid stop bit so a back-to-back start edge is not missed.
      STOP: begin
        baud_cnt_d = baud_next;
        if (strobe) begin
          state_d    = IDLE;
          baud_cnt_d = '0;
          if (!rx_r2_q) begin
            frame_err_d = 1'b1;
          end else if (wfifo_full) begin
            overflow_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = shift_q;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rx_r1_q     <= 1'b1;
      rx_r2_q     <= 1'b1;
      rx_r3_q     <= 1'b1;
      warm_q      <= '0;
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rx_r1_q     <= rs232_rx;
      rx_r2_q     <= rx_r1_q;
      rx_r3_q     <= rx_r2_q;
      warm_q      <= {warm_q[1:0], 1'b1};
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign wfifo_wr_en   = wr_en_q;
  assign wfifo_wr_data = wr_data_q;
  assign frame_err     = frame_err_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed bench for uart_rx_fifo at 29 clocks per bit. A negedge monitor
// counts output pulses and logs written bytes; the main sequence compares
// those records against hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int unsigned BAUD_END = 28;
  localparam int          BIT      = 29;

  logic       sclk;
  logic       s_rst_n;
  logic       rs232_rx;
  logic       wfifo_full;
  logic       wfifo_wr_en;
  logic [7:0] wfifo_wr_data;
  logic       frame_err;
  logic       overflow;

  uart_rx_fifo #(.BAUD_END(BAUD_END)) dut (
    .sclk          (sclk),
    .s_rst_n       (s_rst_n),
    .rs232_rx      (rs232_rx),
    .wfifo_full    (wfifo_full),
    .wfifo_wr_en   (wfifo_wr_en),
    .wfifo_wr_data (wfifo_wr_data),
    .frame_err     (frame_err),
    .overflow      (overflow)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  // Output monitor
  int         wr_cnt   = 0;
  int         fe_cnt   = 0;
  int         ov_cnt   = 0;
  int         long_cnt = 0;
  logic [7:0] data_log [0:63];
  int         cyc_log  [0:63];
  logic       prev_wr  = 1'b0;
  logic       prev_fe  = 1'b0;
  logic       prev_ov  = 1'b0;

  always @(negedge sclk) begin
    if (wfifo_wr_en) begin
      if (wr_cnt < 64) begin
        data_log[wr_cnt] <= wfifo_wr_data;
        cyc_log[wr_cnt]  <= cyc;
      end
      wr_cnt <= wr_cnt + 1;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overflow)  ov_cnt <= ov_cnt + 1;
    if ((wfifo_wr_en && prev_wr) || (frame_err && prev_fe) || (overflow && prev_ov))
      long_cnt <= long_cnt + 1;
    prev_wr <= wfifo_wr_en;
    prev_fe <= frame_err;
    prev_ov <= overflow;
  end

  int checks   = 0;
  int failures = 0;
  int b_wr, b_fe, b_ov;
  int fall_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic snap();
    b_wr = wr_cnt;
    b_fe = fe_cnt;
    b_ov = ov_cnt;
  endtask

  task automatic idle(input int n);
    rs232_rx = 1'b1;
    repeat (n) @(negedge sclk);
  endtask

  task automatic send_bit(input logic v);
    rs232_rx = v;
    repeat (BIT) @(negedge sclk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"},   {31'd0, wfifo_wr_en}, 32'd0);
    chk({tag, "_wr_data"}, {24'd0, wfifo_wr_data}, 32'd0);
    chk({tag, "_fe"},      {31'd0, frame_err},   32'd0);
    chk({tag, "_ov"},      {31'd0, overflow},    32'd0);
  endtask

  initial begin
    s_rst_n    = 1'b0;
    rs232_rx   = 1'b1;
    wfifo_full = 1'b0;
    repeat (4) @(negedge sclk);
    chk_reset_outputs("rst");
    s_rst_n = 1'b1;
    idle(10);

    // Single byte 0xA5 and its latency
    snap();
    send_byte(8'hA5, 1'b1);
    idle(10);
    chk("a5_wr_count", wr_cnt - b_wr, 1);
    chk("a5_data",     {24'd0, data_log[b_wr]}, 32'hA5);
    chk("a5_fe",       fe_cnt - b_fe, 0);
    chk("a5_ov",       ov_cnt - b_ov, 0);
    chk_rng("a5_latency", cyc_log[b_wr] - fall_cyc, 278, 280);

    // Back-to-back 0x00, 0xFF with no idle gap
    snap();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(10);
    chk("b2b_wr_count", wr_cnt - b_wr, 2);
    chk("b2b_data0",    {24'd0, data_log[b_wr]},     32'h00);
    chk("b2b_data1",    {24'd0, data_log[b_wr + 1]}, 32'hFF);
    chk_rng("b2b_spacing", cyc_log[b_wr + 1] - cyc_log[b_wr], 289, 291);

    // 5-cycle glitch, then 0x3C
    snap();
    rs232_rx = 1'b0;
    repeat (5) @(negedge sclk);
    idle(80);
    chk("glitch_wr", wr_cnt - b_wr, 0);
    chk("glitch_fe", fe_cnt - b_fe, 0);
    chk("glitch_ov", ov_cnt - b_ov, 0);
    send_byte(8'h3C, 1'b1);
    idle(10);
    chk("3c_wr_count", wr_cnt - b_wr, 1);
    chk("3c_data",     {24'd0, data_log[b_wr]}, 32'h3C);

    // 0x81 with a low stop bit, then 0x12
    snap();
    send_byte(8'h81, 1'b0);
    idle(40);
    chk("81_fe", fe_cnt - b_fe, 1);
    chk("81_wr", wr_cnt - b_wr, 0);
    send_byte(8'h12, 1'b1);
    idle(10);
    chk("12_wr_count", wr_cnt - b_wr, 1);
    chk("12_data",     {24'd0, data_log[b_wr]}, 32'h12);
    chk("12_fe",       fe_cnt - b_fe, 1);

    // FIFO full: overflow, then normal write
    snap();
    wfifo_full = 1'b1;
    send_byte(8'h7E, 1'b1);
    idle(10);
    chk("full_ov", ov_cnt - b_ov, 1);
    chk("full_wr", wr_cnt - b_wr, 0);
    wfifo_full = 1'b0;
    send_byte(8'h7E, 1'b1);
    idle(10);
    chk("7e_wr_count", wr_cnt - b_wr, 1);
    chk("7e_data",     {24'd0, data_log[b_wr]}, 32'h7E);

    // Frame error takes priority over overflow
    snap();
    wfifo_full = 1'b1;
    send_byte(8'h55, 1'b0);
    idle(40);
    wfifo_full = 1'b0;
    chk("fefull_fe", fe_cnt - b_fe, 1);
    chk("fefull_ov", ov_cnt - b_ov, 0);
    chk("fefull_wr", wr_cnt - b_wr, 0);

    // Reset during data bit 4 of 0xC3, then 0x5A
    snap();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    rs232_rx = 1'b0;
    repeat (10) @(negedge sclk);
    s_rst_n  = 1'b0;
    rs232_rx = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    repeat (5) @(negedge sclk);
    s_rst_n = 1'b1;
    idle(400);
    chk("midrst_wr", wr_cnt - b_wr, 0);
    chk("midrst_fe", fe_cnt - b_fe, 0);
    send_byte(8'h5A, 1'b1);
    idle(10);
    chk("5a_wr_count", wr_cnt - b_wr, 1);
    chk("5a_data",     {24'd0, data_log[b_wr]}, 32'h5A);
    chk("5a_fe",       fe_cnt - b_fe, 0);
    chk("5a_ov",       ov_cnt - b_ov, 0);

    // Break: line held low gives exactly one frame error
    snap();
    rs232_rx = 1'b0;
    repeat (700) @(negedge sclk);
    chk("break_fe", fe_cnt - b_fe, 1);
    chk("break_wr", wr_cnt - b_wr, 0);

    // Reset released with line low: not a start
    s_rst_n = 1'b0;
    repeat (3) @(negedge sclk);
    s_rst_n = 1'b1;
    snap();
    repeat (400) @(negedge sclk);
    chk("lowrel_wr", wr_cnt - b_wr, 0);
    chk("lowrel_fe", fe_cnt - b_fe, 0);
    idle(20);
    send_byte(8'h33, 1'b1);
    idle(10);
    chk("33_wr_count", wr_cnt - b_wr, 1);
    chk("33_data",     {24'd0, data_log[b_wr]}, 32'h33);

    chk("pulse_width", long_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
